// File: rtl/seq_det_pkg.sv
// Shared defaults for the serial pattern detector and a constant-function
// log2 used to size the fill counter.
package seq_det_pkg;

    localparam int         PAT_LEN_DEF = 4;
    localparam int         CNT_W_DEF   = 8;
    localparam logic [3:0] PAT_RST_DEF = 4'b1011;

    // Ceiling log2; clog2(v) bits can hold values 0..v-1.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/seq_det_param_sat_counter.sv
// Saturating up-counter with a sticky flag that rises on the edge where
// the count reaches all-ones. Synchronous clear, async active-high reset.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] q,
    output logic         sat
);

    localparam logic [W-1:0] MAX = '1;

    // Count up on inc, hold at all-ones, latch sat as the top is reached.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q   <= '0;
            sat <= 1'b0;
        end else if (clr) begin
            q   <= '0;
            sat <= 1'b0;
        end else if (inc && (q != MAX)) begin
            q <= q + 1'b1;
            if (q == MAX - 1'b1) sat <= 1'b1;
        end
    end

endmodule

// File: rtl/seq_det_param.sv
// Programmable PAT_LEN-bit serial pattern detector. Bits shift in MSB
// first on in_valid; a hit needs PAT_LEN fresh bits in the history.
// Non-overlap mode restarts the fresh-bit count after every hit.
module seq_det_param
    import seq_det_pkg::*;
#(
    parameter int                 PAT_LEN = PAT_LEN_DEF,
    parameter logic [PAT_LEN-1:0] PAT_RST = PAT_LEN'(PAT_RST_DEF),
    parameter int                 CNT_W   = CNT_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic               in_bit,
    input  logic               overlap,
    input  logic               clear,
    input  logic               pat_load,
    input  logic [PAT_LEN-1:0] pat_in,
    output logic               match,
    output logic [CNT_W-1:0]   match_count,
    output logic               count_sat,
    output logic               armed
);

    localparam int            FW   = clog2(PAT_LEN + 1);
    localparam logic [FW-1:0] FULL = FW'(PAT_LEN);

    logic [PAT_LEN-1:0] pat_reg;
    logic [PAT_LEN-1:0] hist;
    logic [PAT_LEN-1:0] hist_next;
    logic [FW-1:0]      fill;
    logic [FW-1:0]      fill_next;
    logic               shift;
    logic               hit;

    // clear and pat_load both swallow a coincident valid bit.
    assign shift     = in_valid & ~clear & ~pat_load;
    assign hist_next = {hist[PAT_LEN-2:0], in_bit};
    assign fill_next = (fill == FULL) ? fill : fill + 1'b1;
    assign hit       = shift & (fill_next == FULL) & (hist_next == pat_reg);
    assign armed     = (fill == FULL);

    // History, fill and pattern registers plus the registered match pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pat_reg <= PAT_RST;
            hist    <= '0;
            fill    <= '0;
            match   <= 1'b0;
        end else if (clear) begin
            hist  <= '0;
            fill  <= '0;
            match <= 1'b0;
        end else if (pat_load) begin
            pat_reg <= pat_in;
            hist    <= '0;
            fill    <= '0;
            match   <= 1'b0;
        end else begin
            match <= hit;
            if (in_valid) begin
                hist <= hist_next;
                // Non-overlap: history keeps shifting but needs a full refill.
                fill <= (hit && !overlap) ? '0 : fill_next;
            end
        end
    end

    sat_counter #(.W(CNT_W)) u_cnt (
        .clk (clk),
        .rst (rst),
        .inc (hit),
        .clr (clear),
        .q   (match_count),
        .sat (count_sat)
    );

endmodule

// File: tb/tb_seq_det_param.sv
// Scoreboard bench for seq_det_param. Two instances share stimulus:
// index 0 = PAT_LEN 4 / CNT_W 8, index 1 = PAT_LEN 2 / CNT_W 3.
module tb_seq_det_param;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0, in_bit = 1'b0, overlap = 1'b0;
    logic       clear = 1'b0, pat_load = 1'b0;
    logic [3:0] pat_in = '0;

    logic       match_a, sat_a, armed_a;
    logic [7:0] cnt_a;
    logic       match_b, sat_b, armed_b;
    logic [2:0] cnt_b;

    always #5 clk = ~clk;

    seq_det_param #(.PAT_LEN(4), .PAT_RST(4'b1011), .CNT_W(8)) u_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit),
        .overlap(overlap), .clear(clear), .pat_load(pat_load), .pat_in(pat_in),
        .match(match_a), .match_count(cnt_a), .count_sat(sat_a), .armed(armed_a));

    seq_det_param #(.PAT_LEN(2), .PAT_RST(2'b11), .CNT_W(3)) u_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit),
        .overlap(overlap), .clear(clear), .pat_load(pat_load), .pat_in(pat_in[1:0]),
        .match(match_b), .match_count(cnt_b), .count_sat(sat_b), .armed(armed_b));

    typedef struct packed {
        logic [1:0] m;
        logic [1:0] sat;
        logic [1:0] armed;
        logic [7:0] ca;
        logic [2:0] cb;
    } exp_t;

    exp_t sbq[$];
    int   n_cmp = 0;
    int   n_err = 0;

    // Reference model: bits seen since the last flush, count of fresh bits,
    // and a plain integer match count capped at 2^CNT_W-1.
    int plen[2] = '{4, 2};
    int cmax[2] = '{255, 7};
    int prst[2] = '{11, 3};
    int mpat[2], mlast[2], mfresh[2], mcnt[2];
    bit mm[2], msat[2];

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            mpat[k] = prst[k]; mlast[k] = 0; mfresh[k] = 0;
            mcnt[k] = 0; mm[k] = 1'b0; msat[k] = 1'b0;
        end
    endtask

    task automatic model_step(input bit v, input bit b, input bit o,
                              input bit c, input bit l, input int p);
        for (int k = 0; k < 2; k++) begin
            int mask;
            mask  = (1 << plen[k]) - 1;
            mm[k] = 1'b0;
            if (c) begin
                mlast[k] = 0; mfresh[k] = 0; mcnt[k] = 0; msat[k] = 1'b0;
            end else if (l) begin
                mpat[k] = p & mask; mlast[k] = 0; mfresh[k] = 0;
            end else if (v) begin
                mlast[k]  = ((mlast[k] * 2) + int'(b)) & mask;
                mfresh[k] = mfresh[k] + 1;
                if (mfresh[k] >= plen[k] && mlast[k] == mpat[k]) begin
                    mm[k] = 1'b1;
                    if (mcnt[k] < cmax[k]) mcnt[k] = mcnt[k] + 1;
                    if (mcnt[k] == cmax[k]) msat[k] = 1'b1;
                    if (!o) mfresh[k] = 0;
                end
            end
        end
    endtask

    task automatic push_exp();
        exp_t e;
        e.m     = {mm[1], mm[0]};
        e.sat   = {msat[1], msat[0]};
        e.armed = {(mfresh[1] >= plen[1]), (mfresh[0] >= plen[0])};
        e.ca    = 8'(mcnt[0]);
        e.cb    = 3'(mcnt[1]);
        sbq.push_back(e);
    endtask

    // One clock of stimulus; expected outputs for that edge go on the queue.
    task automatic step(input bit v, input bit b, input bit o,
                        input bit c, input bit l, input logic [3:0] p);
        @(negedge clk);
        in_valid = v; in_bit = b; overlap = o; clear = c; pat_load = l; pat_in = p;
        @(posedge clk);
        #1;
        model_step(v, b, o, c, l, int'(p));
        push_exp();
    endtask

    task automatic feed(input bit b, input bit o);
        step(1'b1, b, o, 1'b0, 1'b0, 4'h0);
    endtask

    task automatic idle(input bit o);
        step(1'b0, 1'b0, o, 1'b0, 1'b0, 4'h0);
    endtask

    task automatic feed4(input logic [3:0] bits, input bit o);
        logic [3:0] t;
        t = bits;
        for (int i = 3; i >= 0; i--) feed(t[i], o);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_match_a"}, int'(match_a), 0);
        check({tag, "_cnt_a"},   int'(cnt_a),   0);
        check({tag, "_sat_a"},   int'(sat_a),   0);
        check({tag, "_armed_a"}, int'(armed_a), 0);
        check({tag, "_match_b"}, int'(match_b), 0);
        check({tag, "_cnt_b"},   int'(cnt_b),   0);
        check({tag, "_sat_b"},   int'(sat_b),   0);
        check({tag, "_armed_b"}, int'(armed_b), 0);
    endtask

    // Reset asserted mid-cycle; outputs must drop before the next edge.
    task automatic do_reset();
        idle(1'b0);
        @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1 check_zero("midrst");
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    // Monitor: pops one expectation per cycle and compares every output.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                check("match_a", int'(match_a), int'(e.m[0]));
                check("match_b", int'(match_b), int'(e.m[1]));
                check("cnt_a",   int'(cnt_a),   int'(e.ca));
                check("cnt_b",   int'(cnt_b),   int'(e.cb));
                check("sat_a",   int'(sat_a),   int'(e.sat[0]));
                check("sat_b",   int'(sat_b),   int'(e.sat[1]));
                check("armed_a", int'(armed_a), int'(e.armed[0]));
                check("armed_b", int'(armed_b), int'(e.armed[1]));
            end
        end
    end

    initial begin
        int r;
        bit o;
        model_reset();
        repeat (3) @(posedge clk);
        #1 check_zero("rst");
        @(negedge clk);
        rst = 1'b0;

        // Default pattern 1011, then mid-stream reset and repeat.
        feed4(4'b1011, 1'b1);
        idle(1'b1);
        do_reset();
        feed4(4'b1011, 1'b1);
        idle(1'b1);

        // Overlapping 1010 on 101010.
        step(0, 0, 1, 1, 0, 4'h0);
        step(0, 0, 1, 0, 1, 4'b1010);
        feed4(4'b1010, 1'b1); feed(1, 1); feed(0, 1);
        idle(1'b1);

        // Non-overlapping on the same stream.
        step(0, 0, 0, 1, 0, 4'h0);
        step(0, 0, 0, 0, 1, 4'b1010);
        feed4(4'b1010, 1'b0); feed(1, 0); feed(0, 0);
        idle(1'b0);

        // Gap of five idle cycles inside the pattern.
        step(0, 0, 1, 1, 0, 4'h0);
        step(0, 0, 1, 0, 1, 4'b1011);
        feed(1, 1); feed(0, 1);
        repeat (5) idle(1'b1);
        feed(1, 1); feed(1, 1);
        idle(1'b1);

        // Saturation: ten ones, then clear.
        step(0, 0, 1, 1, 0, 4'h0);
        step(0, 0, 1, 0, 1, 4'b1111);
        repeat (10) feed(1, 1);
        idle(1'b1);
        step(0, 0, 1, 1, 0, 4'h0);
        idle(1'b1);

        // Priority: load with a valid bit, then clear together with load.
        step(1, 1, 1, 0, 1, 4'b1011);
        step(0, 0, 1, 1, 1, 4'b0000);
        feed4(4'b1011, 1'b1);
        idle(1'b1);

        // Random traffic with occasional clear/load and a mid-stream reset.
        o = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if (i == 200) do_reset();
            r = $urandom_range(0, 99);
            if (r < 5) o = ~o;
            if (r < 2)
                step(1'($urandom), 1'($urandom), o, 1'b1, 1'($urandom), 4'($urandom));
            else if (r < 5)
                step(1'($urandom), 1'($urandom), o, 1'b0, 1'b1, 4'($urandom));
            else
                step((r < 75), 1'($urandom), o, 1'b0, 1'b0, 4'h0);
        end
        idle(1'b0);

        for (int i = 0; i < 10 && sbq.size() > 0; i++) @(posedge clk);
        @(negedge clk);
        #1;
        check("queue_drained", sbq.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
